stochastic_computing_bitstream_decoder: RTL
===========================================

// Module: stochastic_computing_bitstream_decoder
// PURPOSE
//   Stochastic-to-binary converter: the receiving end of the stochastic_computing_lfsr_galois encoder path.
//   Counts ones in a unipolar bitstream over one full LFSR period (2^SIZE-1 accepted bits).
//   Returns the count as a binary value through a valid/ready handshake.
//   Sits after stochastic arithmetic stages; closes the LFSR + comparator encoder path.
// PARAMETERS
//   SIZE  8  LFSR width matching the encoder; window WINDOW = 2^SIZE-1 accepted bits; SIZE >= 2
// PORTS
//   i_clk    in   1       clock; all state on rising edge
//   i_rst    in   1       asynchronous reset, active-high
//   i_start  in   1       pulse: clear counters, begin a new window
//   i_en     in   1       bit strobe; i_bit accepted only when i_en=1 in ACCUM
//   i_bit    in   1       stochastic bitstream input
//   o_busy   out  1       1 while in ACCUM
//   o_valid  out  1       result available (HOLD state)
//   i_ready  in   1       consumer accepts result when o_valid & i_ready
//   o_val    out  SIZE+1  decoded result; format set by CONFIGURATION
// BEHAVIOUR
//   Reset (async, immediate):
//     - state=IDLE; o_busy=0, o_valid=0, o_val=0; both counters cleared.
//   FSM states: IDLE, ACCUM, HOLD.
//   IDLE:
//     - i_start=1 -> ACCUM next cycle; bit counter and ones counter cleared.
//     - i_en and i_bit are ignored.
//   ACCUM, each cycle with i_en=1:
//     - bit counter += 1;
//     - ones counter += i_bit.
//   ACCUM, window end:
//     - When the bit counter reaches WINDOW (the WINDOW-th bit is accepted on edge N), o_valid=1 from edge N+1 in HOLD.
//     - One cycle latency after the last accepted bit.
//   ACCUM, restart:
//     - i_start=1 in ACCUM restarts: both counters cleared, stay in ACCUM; i_bit on that cycle is not counted.
//   Counter widths:
//     - Both counters are SIZE bits; ones count <= WINDOW, so no overflow is possible.
//   HOLD:
//     - o_val and o_valid are held stable until the handshake completes; i_en and i_bit are ignored.
//     - i_start without i_ready is ignored; no queuing.
//     - o_valid & i_ready -> IDLE; o_valid=0 next cycle.
//     - o_valid & i_ready & i_start in the same cycle -> ACCUM directly with cleared counters (back-to-back windows).
//   o_val register:
//     - Registered; loaded on the transition into HOLD.
//     - Keeps its last value in IDLE/ACCUM; consumers sample it only when o_valid=1.
//   Reset mid-operation:
//     - Any state -> IDLE; a partial window is discarded.
// CONFIGURATION
//   STOCHASTIC_COMPUTING_DECODER_BIPOLAR_EN
//   - Undefined (unipolar): o_val = {1'b0, ones}, range 0..WINDOW.
//   - Defined (bipolar): o_val = 2*ones - WINDOW as two's complement SIZE+1 bits, range -WINDOW..+WINDOW.
//     The subtraction is registered in the same edge as entry to HOLD; latency is unchanged.
// TESTING (SIZE=4, WINDOW=15)
//   1. i_start; 15 cycles i_en=1,i_bit=1 -> o_valid on the 16th edge after ACCUM entry, o_val=5'd15 (bipolar 5'b01111).
//   2. i_start; 15 accepted zeros -> o_val=5'd0 (bipolar 5'b10001 = -15).
//   3. i_en toggling 1/0 for 30 cycles, 8 ones among the 15 accepted bits -> o_val=8 (bipolar +1).
//      o_valid rises exactly one cycle after the 15th strobe.
//   4. Window done, i_ready=0 for 10 cycles with random i_bit/i_en/i_start -> o_val and o_valid stable.
//      Then i_ready=1 -> IDLE next cycle; i_ready=1 with i_start -> o_busy=1 next cycle.
//   5. Restart and reset:
//      - 7 ones accepted, then i_start, then 15 zeros -> o_val=0.
//      - i_rst mid-ACCUM -> all outputs 0 immediately, state IDLE.
//   6. Loopback with stochastic_computing_lfsr_galois SIZE=4:
//      - LFSR seeded 1, i_bit = (o_val_lfsr <= 9) over one full period -> o_val=9.

Source files
------------

// File: rtl/stochastic_computing_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts ones over one full LFSR period and returns the count via valid/ready.
// Define STOCHASTIC_COMPUTING_DECODER_BIPOLAR_EN for bipolar output (2*ones - WINDOW, two's complement).
module stochastic_computing_bitstream_decoder #(
   parameter int SIZE = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_en,
   input  logic          i_bit,
   output logic          o_busy,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [SIZE:0] o_val
);

   // WINDOW = 2^SIZE-1 is the all-ones SIZE-bit value.
   localparam logic [SIZE-1:0] WINDOW = '1;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] bit_cnt_q, bit_cnt_d;
   logic [SIZE-1:0] ones_q, ones_d;
   logic [SIZE:0]   val_q, val_d;
   logic [SIZE:0]   ones_ext;
   logic [SIZE:0]   result;

   assign ones_ext = {1'b0, ones_q};

`ifdef STOCHASTIC_COMPUTING_DECODER_BIPOLAR_EN
   assign result = (ones_ext << 1) - {1'b0, WINDOW};
`else
   assign result = ones_ext;
`endif

   // The final accepted bit lands on edge N; the full window is seen in the
   // following cycle, giving the one-cycle latency into HOLD.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      ones_d    = ones_q;
      val_d     = val_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d   = ACCUM;
               bit_cnt_d = '0;
               ones_d    = '0;
            end
         end
         ACCUM: begin
            if (i_start) begin
               bit_cnt_d = '0;
               ones_d    = '0;
            end else if (bit_cnt_q == WINDOW) begin
               state_d = HOLD;
               val_d   = result;
            end else if (i_en) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               ones_d    = ones_q + {{(SIZE-1){1'b0}}, i_bit};
            end
         end
         HOLD: begin
            if (i_ready) begin
               if (i_start) begin
                  state_d   = ACCUM;
                  bit_cnt_d = '0;
                  ones_d    = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         ones_q    <= '0;
         val_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         ones_q    <= ones_d;
         val_q     <= val_d;
      end
   end

   assign o_busy  = (state_q == ACCUM);
   assign o_valid = (state_q == HOLD);
   assign o_val   = val_q;

endmodule
